alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Combinational 32-bit integer ALU with a registered 4-bit condition-flag register (C, Z, S, O).
- Sits in the execute stage of the 5-stage pipeline.
- Computes arithmetic/logic/shift results, memory effective-address sums and immediate pass-through.
- Its flags output feeds the branch-condition logic in the same execute stage; flags are restored from the writeback stage on return-from-exception.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; state changes only when high
- opcode  in  5  instruction opcode from decode
- alu_op  in  5  ALU sub-operation (valid for opcode 0/1)
- lhs  in  32  left operand (operand selection is done by the execute stage)
- rhs  in  32  right operand
- bubble_in  in  1  current execute slot is a bubble
- flags_restore  in  32  saved flags word; bits [3:0] are restored
- rfe_in_wb  in  1  return-from-exception in writeback; restores flags
- result  out  32  combinational result
- flags  out  4  registered flags: [0]=C, [1]=Z, [2]=S, [3]=O

Behaviour:
- Reset (async, rst_n=0): flags=4'b0000. result is combinational and carries no reset state.

Result selection (combinational) by opcode:
- 0 (ALU reg) and 1 (ALU imm): operation selected by alu_op.
- 2: result=rhs (immediate pass-through).
- 3..11 (memory address): result=lhs+rhs, 32-bit wrap.
- All other opcodes: result=lhs+rhs; flags never updated.

alu_op encoding:
- 0 and, 1 nand, 2 or, 3 nor, 4 xor, 5 xnor, 6 not(rhs)
- 7 lsl, 8 lsr, 9 asr, 10 rotl, 11 rotr
- 12 lslc (lsl shifting in C), 13 lsrc (lsr shifting in C)
- 14 add, 15 addc (lhs+rhs+C), 16 sub (lhs-rhs), 17 subb (lhs-rhs-!C)
- 18 mul (low 32 bits; only when the optional feature is compiled in)
- 19..31: result=0.

Arithmetic and shift rules:
- Shift/rotate amount is rhs[4:0]. An amount of 0 passes lhs unchanged.

Next-flag computation (for opcode 0/1):
- Z = (result==0). S = result[31].
- add/addc: C=carry out of bit 31; O=signed overflow.
- sub/subb: C=1 when no borrow (lhs >= rhs + borrow, unsigned); O=signed overflow of the subtraction.
- Shifts: C=last bit shifted out (0 when amount is 0; rotates use the bit moved across the boundary); O=0.
- Logic ops, mul, undefined ops: C=0, O=0.

Flag register update at posedge clk, only when clk_en=1:
- rfe_in_wb=1: flags<=flags_restore[3:0]. Takes priority over everything else.
- Otherwise, if !bubble_in and opcode is 0 or 1: flags<=next flags.
- Otherwise flags hold.

Timing and other rules:
- flags output reflects the register only. An ALU instruction's flags are visible the cycle after it executes; a branch immediately following sees them (no bypass).
- clk_en=0 freezes the flag register even if rfe_in_wb=1.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: alu_op 18 produces the low 32 bits of lhs*rhs, with Z/S set from the result and C=O=0.
- Undefined: alu_op 18 behaves as an undefined op (result=0, C=O=0). No multiplier is synthesized.

Decomposition:
- Package alu_pkg holds:
  - opcode constants (OP_ALU_R=0, OP_ALU_I=1, OP_LUI=2, memory range 3..11)
  - alu_op constants (0..18)
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_S=2, FLAG_O=3
- One sub-module, alu_shifter: the combinational shift/rotate unit (lsl/lsr/asr/rotl/rotr/lslc/lsrc) producing the shifted value and carry-out.

Test Plan:
- Reset, then opcode 1, alu_op 14, lhs=0xFFFFFFFF, rhs=1 -> result=0. Next cycle flags=C1 Z1 S0 O0.
- opcode 0, alu_op 16, lhs=5, rhs=7 -> result=0xFFFFFFFE. Next cycle flags: C=0, Z=0, S=1, O=0. Then lhs=0x80000000, rhs=1 -> O=1, C=1.
- opcode 0, alu_op 9, lhs=0x80000001, rhs=1 -> result=0xC0000000, C=1. Same op with rhs=0 -> result=0x80000001, C=0.
- opcode 3, lhs=0x100, rhs=0x8 -> result=0x108, flags unchanged. Same ALU add with bubble_in=1 -> flags unchanged.
- rfe_in_wb=1 with flags_restore=0xA concurrent with a flag-setting add -> flags=4'b1010. Repeat with clk_en=0 -> flags hold.
- Assert rst_n low mid-run with flags=0xF -> flags=0 immediately, without waiting for a clock edge. With ALU_MUL_EN: alu_op 18, 0x10000 * 0x10000 -> result=0, Z=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: opcodes, ALU sub-operations and flag bit positions.
package alu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned OPC_W   = 5;
   localparam int unsigned AOP_W   = 5;
   localparam int unsigned FLAG_W  = 4;

   localparam logic [OPC_W-1:0] OP_ALU_R  = 5'd0;
   localparam logic [OPC_W-1:0] OP_ALU_I  = 5'd1;
   localparam logic [OPC_W-1:0] OP_LUI    = 5'd2;
   localparam logic [OPC_W-1:0] OP_MEM_LO = 5'd3;
   localparam logic [OPC_W-1:0] OP_MEM_HI = 5'd11;

   typedef enum logic [AOP_W-1:0] {
      AOP_AND  = 5'd0,
      AOP_NAND = 5'd1,
      AOP_OR   = 5'd2,
      AOP_NOR  = 5'd3,
      AOP_XOR  = 5'd4,
      AOP_XNOR = 5'd5,
      AOP_NOT  = 5'd6,
      AOP_LSL  = 5'd7,
      AOP_LSR  = 5'd8,
      AOP_ASR  = 5'd9,
      AOP_ROTL = 5'd10,
      AOP_ROTR = 5'd11,
      AOP_LSLC = 5'd12,
      AOP_LSRC = 5'd13,
      AOP_ADD  = 5'd14,
      AOP_ADDC = 5'd15,
      AOP_SUB  = 5'd16,
      AOP_SUBB = 5'd17,
      AOP_MUL  = 5'd18
   } alu_op_e;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_S = 2;
   localparam int unsigned FLAG_O = 3;

   // Opcodes whose alu_op field selects the operation and which may update flags.
   function automatic logic is_alu_opc(input logic [OPC_W-1:0] opc);
      return (opc == OP_ALU_R) || (opc == OP_ALU_I);
   endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit; returns the shifted word and the last bit moved out.
module alu_shifter
   import alu_pkg::*;
(
   input  logic [AOP_W-1:0]   op_i,
   input  logic [DATA_W-1:0]  val_i,
   input  logic [SHAMT_W-1:0] amt_i,
   input  logic               c_i,
   output logic [DATA_W-1:0]  res_o,
   output logic               c_o
);

   localparam logic [DATA_W-1:0] ONES = '1;

   logic [SHAMT_W-1:0] lidx;
   logic [SHAMT_W-1:0] ridx;
   logic [DATA_W-1:0]  cfill;

   // lidx is (32 - amt) mod 32: the source bit that lands last on a left move.
   assign lidx  = SHAMT_W'(0) - amt_i;
   assign ridx  = amt_i - SHAMT_W'(1);
   assign cfill = {DATA_W{c_i}};

   always_comb begin
      res_o = val_i;
      c_o   = 1'b0;
      case (op_i)
         AOP_LSL: begin
            res_o = val_i << amt_i;
            c_o   = val_i[lidx];
         end
         AOP_LSLC: begin
            res_o = (val_i << amt_i) | (~(ONES << amt_i) & cfill);
            c_o   = val_i[lidx];
         end
         AOP_LSR: begin
            res_o = val_i >> amt_i;
            c_o   = val_i[ridx];
         end
         AOP_LSRC: begin
            res_o = (val_i >> amt_i) | (~(ONES >> amt_i) & cfill);
            c_o   = val_i[ridx];
         end
         AOP_ASR: begin
            res_o = $unsigned($signed(val_i) >>> amt_i);
            c_o   = val_i[ridx];
         end
         AOP_ROTL: begin
            res_o = (val_i << amt_i) | (val_i >> lidx);
            c_o   = val_i[lidx];
         end
         AOP_ROTR: begin
            res_o = (val_i >> amt_i) | (val_i << lidx);
            c_o   = val_i[ridx];
         end
         default: ;
      endcase
      // A zero amount passes the operand through and shifts nothing out.
      if (amt_i == '0) begin
         res_o = val_i;
         c_o   = 1'b0;
      end
   end

endmodule

// File: rtl/alu_core.sv
// Execute-stage 32-bit ALU with registered C/Z/S/O flags.
// Build option: define ALU_MUL_EN to enable the 32x32 low-word multiply (alu_op 18).
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic [OPC_W-1:0]  opcode,
   input  logic [AOP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0]  lhs,
   input  logic [WIDTH-1:0]  rhs,
   input  logic              bubble_in,
   input  logic [WIDTH-1:0]  flags_restore,
   input  logic              rfe_in_wb,
   output logic [WIDTH-1:0]  result,
   output logic [FLAG_W-1:0] flags
);

   localparam int unsigned SUM_W = WIDTH + 1;

   logic [FLAG_W-1:0] flags_q;
   logic [FLAG_W-1:0] flags_d;

   logic [WIDTH-1:0]  shift_res;
   logic              shift_c;
   logic              sub_op;
   logic              add_cin;
   logic [WIDTH-1:0]  b_op;
   logic [SUM_W-1:0]  sum;
   logic              add_ovf;
   logic [WIDTH-1:0]  addr_sum;
   logic [WIDTH-1:0]  mul_res;
   logic [WIDTH-1:0]  alu_res;
   logic              c_nxt;
   logic              o_nxt;
   logic              unused_restore_bits;

   assign unused_restore_bits = ^flags_restore[WIDTH-1:FLAG_W];

   alu_shifter u_shifter (
      .op_i  (alu_op),
      .val_i (lhs),
      .amt_i (rhs[SHAMT_W-1:0]),
      .c_i   (flags_q[FLAG_C]),
      .res_o (shift_res),
      .c_o   (shift_c)
   );

   // Shared adder: subtraction is lhs + ~rhs + carry, so carry-out means "no borrow".
   always_comb begin
      sub_op  = (alu_op == AOP_SUB) || (alu_op == AOP_SUBB);
      b_op    = sub_op ? ~rhs : rhs;
      add_cin = 1'b0;
      case (alu_op)
         AOP_ADDC, AOP_SUBB: add_cin = flags_q[FLAG_C];
         AOP_SUB:            add_cin = 1'b1;
         default:            add_cin = 1'b0;
      endcase
      sum     = {1'b0, lhs} + {1'b0, b_op} + SUM_W'(add_cin);
      add_ovf = (lhs[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != lhs[WIDTH-1]);
   end

   assign addr_sum = lhs + rhs;

`ifdef ALU_MUL_EN
   assign mul_res = lhs * rhs;
`else
   assign mul_res = '0;
`endif

   // ALU sub-operation result plus the carry/overflow it would produce.
   always_comb begin
      alu_res = '0;
      c_nxt   = 1'b0;
      o_nxt   = 1'b0;
      case (alu_op)
         AOP_AND:  alu_res = lhs & rhs;
         AOP_NAND: alu_res = ~(lhs & rhs);
         AOP_OR:   alu_res = lhs | rhs;
         AOP_NOR:  alu_res = ~(lhs | rhs);
         AOP_XOR:  alu_res = lhs ^ rhs;
         AOP_XNOR: alu_res = ~(lhs ^ rhs);
         AOP_NOT:  alu_res = ~rhs;
         AOP_LSL, AOP_LSR, AOP_ASR, AOP_ROTL, AOP_ROTR, AOP_LSLC, AOP_LSRC: begin
            alu_res = shift_res;
            c_nxt   = shift_c;
         end
         AOP_ADD, AOP_ADDC, AOP_SUB, AOP_SUBB: begin
            alu_res = sum[WIDTH-1:0];
            c_nxt   = sum[WIDTH];
            o_nxt   = add_ovf;
         end
         AOP_MUL:  alu_res = mul_res;
         default:  alu_res = '0;
      endcase
   end

   // Memory opcodes and every unassigned opcode share the address adder.
   always_comb begin
      result = addr_sum;
      if (is_alu_opc(opcode)) begin
         result = alu_res;
      end else if (opcode == OP_LUI) begin
         result = rhs;
      end
   end

   // Exception return wins over an ALU update in the same cycle.
   always_comb begin
      flags_d = flags_q;
      if (rfe_in_wb) begin
         flags_d = flags_restore[FLAG_W-1:0];
      end else if (!bubble_in && is_alu_opc(opcode)) begin
         flags_d[FLAG_C] = c_nxt;
         flags_d[FLAG_Z] = (alu_res == '0);
         flags_d[FLAG_S] = alu_res[WIDTH-1];
         flags_d[FLAG_O] = o_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (clk_en) begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus queues expected results/flags, a monitor checks them.
module tb_alu_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic [4:0]  opcode;
   logic [4:0]  alu_op;
   logic [31:0] lhs;
   logic [31:0] rhs;
   logic        bubble_in;
   logic [31:0] flags_restore;
   logic        rfe_in_wb;
   logic [31:0] result;
   logic [3:0]  flags;

   typedef struct {
      int          cyc;
      bit          is_flg;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   event sample_ev;

   alu_core #(.WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clk_en        (clk_en),
      .opcode        (opcode),
      .alu_op        (alu_op),
      .lhs           (lhs),
      .rhs           (rhs),
      .bubble_in     (bubble_in),
      .flags_restore (flags_restore),
      .rfe_in_wb     (rfe_in_wb),
      .result        (result),
      .flags         (flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input bit f, input logic [31:0] v, input string n);
      exp_t e;
      e.cyc    = c;
      e.is_flg = f;
      e.val    = v;
      e.name   = n;
      sb.push_back(e);
   endtask

   // Monitor: compares every expectation that has come due.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clk or sample_ev);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = e.is_flg ? {28'd0, flags} : result;
            checks++;
            if (act !== e.val) begin
               failures++;
               $display("FAIL %s%s: got 0x%08h expected 0x%08h",
                        e.name, e.is_flg ? ".flags" : ".result", act, e.val);
            end
         end
      end
   end

   task automatic ctl(input string nm, input logic [4:0] opc, input logic [4:0] aop,
                      input logic [31:0] l, input logic [31:0] r,
                      input logic bub, input logic rfe, input logic en,
                      input logic [31:0] rst_w,
                      input logic [31:0] exp_res, input logic [3:0] exp_flg);
      @(posedge clk);
      #1;
      opcode        = opc;
      alu_op        = aop;
      lhs           = l;
      rhs           = r;
      bubble_in     = bub;
      rfe_in_wb     = rfe;
      clk_en        = en;
      flags_restore = rst_w;
      push(cyc, 1'b0, exp_res, nm);
      push(cyc + 1, 1'b1, {28'd0, exp_flg}, nm);
   endtask

   task automatic alu(input string nm, input logic [4:0] opc, input logic [4:0] aop,
                      input logic [31:0] l, input logic [31:0] r,
                      input logic [31:0] exp_res, input logic [3:0] exp_flg);
      ctl(nm, opc, aop, l, r, 1'b0, 1'b0, 1'b1, 32'd0, exp_res, exp_flg);
   endtask

   // Reset asserted between clock edges must clear flags before the next rising edge.
   task automatic reset_mid();
      @(posedge clk);
      @(negedge clk);
      #1;
      bubble_in = 1'b1;
      rfe_in_wb = 1'b0;
      rst_n     = 1'b0;
      #1;
      push(cyc, 1'b1, 32'd0, "async_rst");
      ->sample_ev;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      clk_en        = 1'b1;
      opcode        = 5'd0;
      alu_op        = 5'd0;
      lhs           = 32'd0;
      rhs           = 32'd0;
      bubble_in     = 1'b1;
      flags_restore = 32'd0;
      rfe_in_wb     = 1'b0;
      @(posedge clk);
      #1;
      push(cyc, 1'b1, 32'd0, "reset");
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      // Flag order in expectations: {O,S,Z,C}
      alu("add_wrap",   5'd1, 5'd14, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 4'b0011);
      alu("sub_neg",    5'd0, 5'd16, 32'd5,         32'd7,        32'hFFFF_FFFE, 4'b0100);
      alu("sub_ovf",    5'd0, 5'd16, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 4'b1001);
      alu("asr_1",      5'd0, 5'd9,  32'h8000_0001, 32'd1,        32'hC000_0000, 4'b0101);
      alu("asr_0",      5'd0, 5'd9,  32'h8000_0001, 32'd0,        32'h8000_0001, 4'b0100);
      alu("mem_addr",   5'd3, 5'd14, 32'h0000_0100, 32'h8,        32'h0000_0108, 4'b0100);
      ctl("bubble_add", 5'd0, 5'd14, 32'd1, 32'd1, 1'b1, 1'b0, 1'b1, 32'd0,          32'd2, 4'b0100);
      ctl("rfe_prio",   5'd0, 5'd14, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFA,  32'd2, 4'b1010);
      ctl("rfe_gated",  5'd0, 5'd14, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0, 32'h0000_0005,  32'd2, 4'b1010);
      alu("add_ovf",    5'd0, 5'd14, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 4'b1100);
      alu("sub_zero",   5'd0, 5'd16, 32'd3,         32'd3,        32'h0000_0000, 4'b0011);
      alu("addc_c1",    5'd0, 5'd15, 32'd1,         32'd1,        32'h0000_0003, 4'b0000);
      alu("subb_c0",    5'd0, 5'd17, 32'd5,         32'd3,        32'h0000_0001, 4'b0001);
      alu("rotl_1",     5'd0, 5'd10, 32'h8000_0001, 32'd1,        32'h0000_0003, 4'b0001);
      alu("lsl_2",      5'd0, 5'd7,  32'h4000_0000, 32'd2,        32'h0000_0000, 4'b0011);
      alu("lslc_1",     5'd0, 5'd12, 32'd1,         32'd1,        32'h0000_0003, 4'b0000);
      alu("rotr_1",     5'd0, 5'd11, 32'd1,         32'd1,        32'h8000_0000, 4'b0101);
      alu("nor_0",      5'd0, 5'd3,  32'd0,         32'd0,        32'hFFFF_FFFF, 4'b0100);
      alu("xnor",       5'd1, 5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF00F_F00F, 4'b0100);
      alu("lui",        5'd2, 5'd0,  32'h0000_DEAD, 32'h1234_5678, 32'h1234_5678, 4'b0100);
      alu("undef_op",   5'd0, 5'd20, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 4'b0010);
`ifdef ALU_MUL_EN
      alu("mul_3x5",    5'd0, 5'd18, 32'd3,         32'd5,        32'd15,        4'b0000);
      alu("mul_wrap",   5'd0, 5'd18, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0010);
`else
      alu("mul_off",    5'd0, 5'd18, 32'd3,         32'd5,        32'h0000_0000, 4'b0010);
`endif
      alu("other_opc",  5'd12, 5'd14, 32'd1,        32'd2,        32'h0000_0003, 4'b0010);
      ctl("rfe_all",    5'd0, 5'd0,  32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h0000_000F,  32'd0, 4'b1111);
      reset_mid();
      alu("post_rst",   5'd1, 5'd0,  32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 4'b0010);

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
